// File: rtl/quad_step_pkg.sv
// Shared types and helpers for the quadrature step controller.
//   state_e      : controller FSM state (idle / running a move)
//   DIR_FWD/REV  : encoding of the direction bit
//   phase_encode : 2-bit phase index -> {A, B} Gray-coded phase pair
package quad_step_pkg;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Index 0..3 maps to (A,B) = 10, 11, 01, 00, so consecutive indices differ in one bit.
  function automatic logic [1:0] phase_encode(input logic [1:0] p);
    return {~p[1], p[1] ^ p[0]};
  endfunction

endpackage

// File: rtl/quad_phase_seq.sv
// Quadrature phase sequencer: 2-bit up/down phase index with registered A/B outputs.
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high; index -> 0, (A,B) -> 10
//   step_en  in   advance the phase index by one step this edge
//   dir      in   1 = forward (index +1), 0 = reverse (index -1)
//   phase_a  out  registered phase A
//   phase_b  out  registered phase B
module quad_phase_seq
  import quad_step_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic step_en,
  input  logic dir,
  output logic phase_a,
  output logic phase_b
);

  logic [1:0] p_q, p_d;
  logic [1:0] ab_q, ab_d;

  always_comb begin
    p_d  = p_q;
    ab_d = ab_q;
    if (step_en) begin
      p_d  = (dir == DIR_FWD) ? p_q + 2'd1 : p_q - 2'd1;
      ab_d = phase_encode(p_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_q  <= 2'd0;
      ab_q <= phase_encode(2'd0);
    end else begin
      p_q  <= p_d;
      ab_q <= ab_d;
    end
  end

  assign phase_a = ab_q[1];
  assign phase_b = ab_q[0];

endmodule

// File: rtl/quad_step_controller.sv
// Command-driven quadrature step controller.
// Accepts a move (direction, step count, step period) over a valid/ready handshake, issues
// that many Gray-coded A/B steps at one step every period clocks, and tracks a signed,
// wrapping absolute position. Each command ends with a one-cycle done or aborted pulse.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   cmd_valid/cmd_ready command handshake (ready only while idle)
//   cmd_dir             1 = forward, 0 = reverse
//   cmd_steps           number of steps (0 completes immediately)
//   cmd_period          clocks per step (0 treated as 1)
//   abort               stop the current move; ignored while idle
//   phase_a, phase_b    registered quadrature outputs
//   busy                move in progress
//   done, aborted       one-cycle completion / abort pulses
//   position            signed step position, wraps modulo 2^POS_W
module quad_step_controller
  import quad_step_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned POS_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic             phase_a,
  output logic             phase_b,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [POS_W-1:0] position
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);
  localparam logic [POS_W-1:0] PosOne = POS_W'(1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] reload_q, reload_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic [DIV_W-1:0] period_m1;
  logic             step_en;

  // A period of 0 behaves like 1, so both reload a divider value of 0.
  assign period_m1 = (cmd_period == '0) ? '0 : cmd_period - DivOne;

  // Abort wins over a coinciding step tick.
  assign step_en = (state_q == StRun) && !abort && (div_q == '0);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    reload_d  = reload_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    pos_d     = pos_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = StRun;
            dir_d    = cmd_dir;
            rem_d    = cmd_steps;
            reload_d = period_m1;
            div_d    = period_m1;
          end
        end
      end
      StRun: begin
        if (abort) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
          div_d     = '0;
          rem_d     = '0;
        end else if (div_q == '0) begin
          pos_d = (dir_q == DIR_FWD) ? pos_q + PosOne : pos_q - PosOne;
          rem_d = rem_q - CntOne;
          div_d = reload_q;
          if (rem_q == CntOne) begin
            state_d = StIdle;
            done_d  = 1'b1;
            div_d   = '0;
          end
        end else begin
          div_d = div_q - DivOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      div_q     <= '0;
      reload_q  <= '0;
      rem_q     <= '0;
      dir_q     <= DIR_REV;
      pos_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      reload_q  <= reload_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      pos_q     <= pos_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  quad_phase_seq u_phase_seq (
    .clk     (clk),
    .reset   (reset),
    .step_en (step_en),
    .dir     (dir_q),
    .phase_a (phase_a),
    .phase_b (phase_b)
  );

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign position  = pos_q;

endmodule

// File: tb/tb_quad_step_controller.sv
// Bench for quad_step_controller: directed scenarios followed by randomized moves, all
// checked against a move-level reference model (steps land at accept + i*P).
// A second instance with a 3-bit position shares the stimulus to exercise wrapping.
module tb_quad_step_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;

  logic        cmd_ready, phase_a, phase_b, busy, done, aborted;
  logic [31:0] position;
  logic        cmd_ready_s, phase_a_s, phase_b_s, busy_s, done_s, aborted_s;
  logic [2:0]  position_s;

  always #5 clk = ~clk;

  quad_step_controller u_dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .phase_a    (phase_a),
    .phase_b    (phase_b),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .position   (position)
  );

  quad_step_controller #(.POS_W(3)) u_dut_small (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready_s),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .phase_a    (phase_a_s),
    .phase_b    (phase_b_s),
    .busy       (busy_s),
    .done       (done_s),
    .aborted    (aborted_s),
    .position   (position_s)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: phase index and absolute position.
  logic [1:0]  m_p   = 2'd0;
  logic [31:0] m_pos = '0;
  logic [1:0]  ab_tbl [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic eb, input logic ed, input logic ea);
    logic [1:0] ab;
    logic [2:0] ps;
    ab = ab_tbl[m_p];
    ps = m_pos[2:0];
    chk({tag, ".ab"}, {30'b0, phase_a, phase_b}, {30'b0, ab});
    chk({tag, ".ab_s"}, {30'b0, phase_a_s, phase_b_s}, {30'b0, ab});
    chk({tag, ".pos"}, position, m_pos);
    chk({tag, ".pos_s"}, {29'b0, position_s}, {29'b0, ps});
    chk({tag, ".flags"}, {28'b0, busy, done, aborted, cmd_ready}, {28'b0, eb, ed, ea, ~eb});
    chk({tag, ".flags_s"}, {28'b0, busy_s, done_s, aborted_s, cmd_ready_s},
        {28'b0, eb, ed, ea, ~eb});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_p   = 2'd0;
    m_pos = '0;
    check_all("reset", 1'b0, 1'b0, 1'b0);
  endtask

  // Offer a command for one edge, then follow the move cycle by cycle.
  // abort_at = t raises abort before edge accept+t (0 = never).
  task automatic run_move(input logic d, input int n, input int per, input int abort_at,
                          input logic idle_abort);
    int pe;
    int issued;
    pe         = (per == 0) ? 1 : per;
    issued     = 0;
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = n[15:0];
    cmd_period = per[15:0];
    abort      = idle_abort;
    tick();
    cmd_valid = 1'b0;
    abort     = 1'b0;
    if (n == 0) begin
      check_all("zero", 1'b0, 1'b1, 1'b0);
      return;
    end
    check_all("accept", 1'b1, 1'b0, 1'b0);
    for (int t = 1; t <= n * pe; t++) begin
      abort      = (t == abort_at);
      cmd_valid  = 1'($urandom);
      cmd_dir    = 1'($urandom);
      cmd_steps  = 16'($urandom);
      cmd_period = 16'($urandom);
      tick();
      if (t == abort_at) begin
        abort     = 1'b0;
        cmd_valid = 1'b0;
        check_all("abort", 1'b0, 1'b0, 1'b1);
        return;
      end
      if (t % pe == 0) begin
        issued++;
        m_p   = d ? m_p + 2'd1 : m_p - 2'd1;
        m_pos = d ? m_pos + 32'd1 : m_pos - 32'd1;
      end
      if (issued == n) begin
        cmd_valid = 1'b0;
        check_all("done", 1'b0, 1'b1, 1'b0);
      end else begin
        check_all("run", 1'b1, 1'b0, 1'b0);
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    int n, per, ab_at;
    logic d;

    // Reset state.
    tick();
    do_reset();

    // Forward 4 steps, period 3: 11, 01, 00, 10; position 4 (3-bit copy wraps to -4).
    run_move(1'b1, 4, 3, 0, 1'b0);
    chk("t1.pos4", position, 32'd4);

    // Reverse 2 steps, period 1, from p=0: 00 then 01; position -2.
    do_reset();
    run_move(1'b0, 2, 1, 0, 1'b0);
    chk("t2.neg2", position, 32'hFFFF_FFFE);

    // Zero-step command; abort in idle is ignored.
    run_move(1'b1, 0, 3, 0, 1'b1);

    // Abort on the 3rd step tick: only 2 steps issued.
    do_reset();
    run_move(1'b1, 10, 5, 15, 1'b0);
    chk("t4.pos2", position, 32'd2);
    tick();
    check_all("t4.idle", 1'b0, 1'b0, 1'b0);

    // Back-to-back: second command offered in the done cycle, period 0 acts as 1.
    run_move(1'b1, 3, 2, 0, 1'b0);
    run_move(1'b0, 2, 0, 0, 1'b0);
    run_move(1'b1, 5, 1, 0, 1'b1);

    // Reset in the middle of a move.
    cmd_valid  = 1'b1;
    cmd_dir    = 1'b1;
    cmd_steps  = 16'd10;
    cmd_period = 16'd2;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    m_p   = m_p + 2'd3;
    m_pos = m_pos + 32'd3;
    check_all("t6.pre", 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_p   = 2'd0;
    m_pos = '0;
    check_all("t6.rst", 1'b0, 1'b0, 1'b0);
    tick();
    check_all("t6.after", 1'b0, 1'b0, 1'b0);

    // Randomized moves, some aborted, some back-to-back.
    for (int k = 0; k < 40; k++) begin
      d     = 1'($urandom);
      n     = int'($urandom_range(0, 6));
      per   = int'($urandom_range(0, 4));
      ab_at = 0;
      if (n > 0 && $urandom_range(0, 3) == 0)
        ab_at = int'($urandom_range(1, n * ((per == 0) ? 1 : per)));
      run_move(d, n, per, ab_at, 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check_all("gap", 1'b0, 1'b0, 1'b0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
